// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer:
// FSM state encoding and stat_out select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        STOP  = 2'd2
    } state_e;

    localparam logic [1:0] STAT_CYCLES  = 2'd0;
    localparam logic [1:0] STAT_STALLS  = 2'd1;
    localparam logic [1:0] STAT_FLUSHES = 2'd2;
    localparam logic [1:0] STAT_RETIRED = 2'd3;

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Hazard/SYSCALL requests in, stage enables and bubbles out.
// master = sequencer, slave = pipeline datapath.
interface pipe_stage_ctrl_if;

    logic data_hazard;
    logic branch_taken;
    logic sys_pause;
    logic sys_exit;
    logic wb_valid;
    logic PC_EN;
    logic EN1;
    logic EN2;
    logic EN3;
    logic EN4;
    logic flush_ifid;
    logic flush_idex;

    modport master (
        input  data_hazard, branch_taken,
        input  sys_pause, sys_exit, wb_valid,
        output PC_EN, EN1, EN2, EN3, EN4,
        output flush_ifid, flush_idex
    );

    modport slave (
        output data_hazard, branch_taken,
        output sys_pause, sys_exit, wb_valid,
        input  PC_EN, EN1, EN2, EN3, EN4,
        input  flush_ifid, flush_idex
    );

endinterface

// File: rtl/pipe_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         CLR,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!CLR) begin
            q <= '0;
        end else if (inc && !(&q)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencer: stall/flush/pause/exit FSM driving
// stage enables, plus saturating performance counters.
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               CLR,
    input  logic               GO,
    input  logic [1:0]         stat_sel,
    pipe_stage_ctrl_if.master  bus,
    output logic               halted,
    output logic               stopped,
    output logic [CNT_W-1:0]   stat_out
);

    state_e state_q, state_d;
    logic   go_q;
    logic   resume_q, resume_d;
    logic   go_rise;
    logic   in_run;

    logic [4:0] en;
    logic [1:0] fl;

    logic [CNT_W-1:0] cnt_cyc, cnt_stl, cnt_fls, cnt_ret;

    assign go_rise = GO & ~go_q;
    assign in_run  = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (!CLR) begin
            state_q  <= RUN;
            go_q     <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            go_q     <= GO;
            resume_q <= resume_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        resume_d = 1'b0;
        en       = '0;
        fl       = '0;
        unique case (state_q)
            RUN: begin
                // branch wins: the stalled ID instruction is wrong-path
                if (bus.branch_taken) begin
                    en = 5'b11111;
                    fl = 2'b11;
                end else if (bus.data_hazard) begin
                    en = 5'b00111;
                    fl = 2'b01;
                end else begin
                    en = 5'b11111;
                end
                if (!resume_q) begin
                    if (bus.sys_exit) begin
                        state_d = STOP;
                    end else if (bus.sys_pause) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (go_rise) begin
                    state_d  = RUN;
                    resume_d = 1'b1;
                end
            end
            STOP: begin
                state_d = STOP;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!CLR) begin
            en = '0;
            fl = '0;
        end
    end

    assign bus.PC_EN      = en[4];
    assign bus.EN1        = en[3];
    assign bus.EN2        = en[2];
    assign bus.EN3        = en[1];
    assign bus.EN4        = en[0];
    assign bus.flush_ifid = fl[1];
    assign bus.flush_idex = fl[0];

    assign halted  = (state_q == PAUSE);
    assign stopped = (state_q == STOP);

    sat_counter #(.W(CNT_W)) u_cyc (
        .clk (clk),
        .CLR (CLR),
        .inc (in_run),
        .q   (cnt_cyc)
    );

    sat_counter #(.W(CNT_W)) u_stl (
        .clk (clk),
        .CLR (CLR),
        .inc (in_run & bus.data_hazard & ~bus.branch_taken),
        .q   (cnt_stl)
    );

    sat_counter #(.W(CNT_W)) u_fls (
        .clk (clk),
        .CLR (CLR),
        .inc (in_run & bus.branch_taken),
        .q   (cnt_fls)
    );

    sat_counter #(.W(CNT_W)) u_ret (
        .clk (clk),
        .CLR (CLR),
        .inc (in_run & bus.wb_valid),
        .q   (cnt_ret)
    );

    always_comb begin
        stat_out = '0;
        unique case (stat_sel)
            STAT_CYCLES:  stat_out = cnt_cyc;
            STAT_STALLS:  stat_out = cnt_stl;
            STAT_FLUSHES: stat_out = cnt_fls;
            STAT_RETIRED: stat_out = cnt_ret;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: directed vectors,
// plus a 4-bit instance for counter saturation.
module tb_pipe_stage_ctrl;

    typedef struct {
        logic [4:0]  en;
        logic [1:0]  fl;
        logic        h;
        logic        s;
        logic        cs;
        logic [31:0] st;
        logic        chk2;
        logic [3:0]  st2;
    } exp_t;

    localparam logic [4:0] E_ALL  = 5'b11111;
    localparam logic [4:0] E_STL  = 5'b00111;
    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [1:0] F_NO   = 2'b00;
    localparam logic [1:0] F_IDEX = 2'b01;
    localparam logic [1:0] F_BOTH = 2'b11;

    logic        clk;
    logic        CLR;
    logic        GO;
    logic [1:0]  stat_sel;
    logic        halted;
    logic        stopped;
    logic [31:0] stat_out;

    logic        clr2;
    logic        clr2_n;
    logic        go2;
    logic [1:0]  sel2;
    logic        halted2;
    logic        stopped2;
    logic [3:0]  stat2;

    exp_t sb[$];
    exp_t e_m;
    int   n_vec;
    int   n_bad;
    int   vid;

    pipe_stage_ctrl_if bus ();
    pipe_stage_ctrl_if bus2 ();

    pipe_stage_ctrl #(.CNT_W(32)) dut (
        .clk      (clk),
        .CLR      (CLR),
        .GO       (GO),
        .stat_sel (stat_sel),
        .bus      (bus),
        .halted   (halted),
        .stopped  (stopped),
        .stat_out (stat_out)
    );

    pipe_stage_ctrl #(.CNT_W(4)) dut_sat (
        .clk      (clk),
        .CLR      (clr2),
        .GO       (go2),
        .stat_sel (sel2),
        .bus      (bus2),
        .halted   (halted2),
        .stopped  (stopped2),
        .stat_out (stat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(
        input logic [4:0]  en,
        input logic [1:0]  fl,
        input logic        h,
        input logic        s,
        input logic        cs,
        input logic [31:0] st
    );
        exp_t r;
        r.en   = en;
        r.fl   = fl;
        r.h    = h;
        r.s    = s;
        r.cs   = cs;
        r.st   = st;
        r.chk2 = 1'b0;
        r.st2  = 4'd0;
        return r;
    endfunction

    task automatic step(
        input logic       clr,
        input logic       go,
        input logic       dh,
        input logic       bt,
        input logic       sp,
        input logic       se,
        input logic       wv,
        input logic [1:0] sel,
        input exp_t       e
    );
        @(posedge clk);
        #1;
        CLR              = clr;
        GO               = go;
        bus.data_hazard  = dh;
        bus.branch_taken = bt;
        bus.sys_pause    = sp;
        bus.sys_exit     = se;
        bus.wb_valid     = wv;
        stat_sel         = sel;
        clr2             = clr2_n;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [4:0] g_en;
            logic [1:0] g_fl;
            logic       bad;
            e_m  = sb.pop_front();
            vid  = vid + 1;
            n_vec = n_vec + 1;
            g_en = {bus.PC_EN, bus.EN1, bus.EN2,
                    bus.EN3, bus.EN4};
            g_fl = {bus.flush_ifid, bus.flush_idex};
            bad  = (g_en !== e_m.en) || (g_fl !== e_m.fl)
                || (halted !== e_m.h) || (stopped !== e_m.s)
                || (e_m.cs && (stat_out !== e_m.st))
                || (e_m.chk2 && (stat2 !== e_m.st2));
            if (bad) begin
                n_bad = n_bad + 1;
                $display("FAIL vec%0d en=%b/%b fl=%b/%b h=%b/%b s=%b/%b st=%0d/%0d sat=%0d/%0d",
                         vid, g_en, e_m.en, g_fl, e_m.fl,
                         halted, e_m.h, stopped, e_m.s,
                         stat_out, e_m.st, stat2, e_m.st2);
            end
        end
    end

    initial begin
        exp_t e;
        n_vec = 0;
        n_bad = 0;
        vid   = 0;
        CLR = 1'b0;
        GO = 1'b0;
        stat_sel = 2'd0;
        bus.data_hazard = 1'b0;
        bus.branch_taken = 1'b0;
        bus.sys_pause = 1'b0;
        bus.sys_exit = 1'b0;
        bus.wb_valid = 1'b0;
        clr2 = 1'b0;
        clr2_n = 1'b0;
        go2 = 1'b0;
        sel2 = 2'd0;
        bus2.data_hazard = 1'b0;
        bus2.branch_taken = 1'b0;
        bus2.sys_pause = 1'b0;
        bus2.sys_exit = 1'b0;
        bus2.wb_valid = 1'b0;

        // reset with GO high
        step(0,1,0,0,0,0,0,0, mk(E_NONE,F_NO,0,0,1,0));
        step(0,1,0,0,0,0,0,0, mk(E_NONE,F_NO,0,0,1,0));
        // every counter reads zero
        step(1,0,0,0,0,0,0,0, mk(E_ALL,F_NO,0,0,1,0));
        step(1,0,0,0,0,0,0,1, mk(E_ALL,F_NO,0,0,1,0));
        step(1,0,0,0,0,0,0,2, mk(E_ALL,F_NO,0,0,1,0));
        step(1,0,0,0,0,0,0,3, mk(E_ALL,F_NO,0,0,1,0));
        // three stall cycles
        step(1,0,1,0,0,0,0,1, mk(E_STL,F_IDEX,0,0,1,0));
        step(1,0,1,0,0,0,0,1, mk(E_STL,F_IDEX,0,0,1,1));
        step(1,0,1,0,0,0,0,1, mk(E_STL,F_IDEX,0,0,1,2));
        step(1,0,0,0,0,0,0,1, mk(E_ALL,F_NO,0,0,1,3));
        step(1,0,0,0,0,0,0,0, mk(E_ALL,F_NO,0,0,1,8));
        // branch and hazard together
        step(1,0,1,1,0,0,0,1, mk(E_ALL,F_BOTH,0,0,1,3));
        step(1,0,0,0,0,0,0,1, mk(E_ALL,F_NO,0,0,1,3));
        step(1,0,0,0,0,0,0,2, mk(E_ALL,F_NO,0,0,1,1));
        // retired count
        step(1,0,0,0,0,0,1,3, mk(E_ALL,F_NO,0,0,1,0));
        step(1,0,0,0,0,0,0,3, mk(E_ALL,F_NO,0,0,1,1));
        // pause entry with GO already high
        step(1,1,0,0,1,0,0,0, mk(E_ALL,F_NO,0,0,1,14));
        step(1,1,1,1,1,0,0,0, mk(E_NONE,F_NO,1,0,1,15));
        step(1,1,0,0,1,0,0,0, mk(E_NONE,F_NO,1,0,1,15));
        step(1,0,0,0,1,0,0,0, mk(E_NONE,F_NO,1,0,1,15));
        step(1,1,0,0,1,0,0,0, mk(E_NONE,F_NO,1,0,1,15));
        // resume cycle ignores the lingering sys_pause
        step(1,1,0,0,1,0,0,0, mk(E_ALL,F_NO,0,0,1,15));
        step(1,0,0,0,0,0,0,0, mk(E_ALL,F_NO,0,0,1,16));
        // exit beats pause; GO edges ignored in STOP
        step(1,0,0,0,1,1,0,0, mk(E_ALL,F_NO,0,0,1,17));
        step(1,1,0,0,0,0,0,0, mk(E_NONE,F_NO,0,1,1,18));
        step(1,0,0,0,0,0,0,0, mk(E_NONE,F_NO,0,1,1,18));
        step(1,1,0,0,0,0,0,0, mk(E_NONE,F_NO,0,1,1,18));
        step(0,0,0,0,0,0,0,0, mk(E_NONE,F_NO,0,1,1,18));
        step(1,0,0,0,0,0,0,0, mk(E_ALL,F_NO,0,0,1,0));
        step(1,0,0,0,0,0,0,2, mk(E_ALL,F_NO,0,0,1,0));
        step(1,0,0,0,0,0,0,1, mk(E_ALL,F_NO,0,0,1,0));

        // 4-bit cycles counter saturates at 15
        clr2_n = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            e = mk(E_ALL,F_NO,0,0,0,0);
            if (k == 1 || k == 15 || k == 16 || k == 17 || k == 22) begin
                e.chk2 = 1'b1;
                e.st2  = (k - 1 > 15) ? 4'hF : 4'(k - 1);
            end
            step(1,0,0,0,0,0,0,0, e);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
